bldc_speed_ramp_sequencer: RTL
==============================

Name: bldc_speed_ramp_sequencer

Overview:
Sequences the BLDC commutation controller. It accepts start/stop commands and a target speed, and slews the controller's 8-bit speed_set toward the target at a programmable rate. It monitors the hall inputs for stall and illegal codes, and latches a coded fault that forces speed to zero. It sits between the host/register interface and the commutation FSM, driving that FSM's speed_set and fault inputs.

Parameters:
STEP, 1, speed_set increment/decrement per ramp tick (1..255)
DIV_W, 16, width of ramp_div and the ramp tick counter
STALL_W, 20, width of stall_limit and the stall counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  run request pulse/level, sampled each cycle
stop  in  1  controlled stop request, sampled each cycle
fault_in  in  1  external fault (overcurrent etc.), level
clear_fault  in  1  fault acknowledge, sampled in FAULT only
target_speed  in  8  requested speed
ramp_div  in  DIV_W  clocks between ramp ticks minus 1 (0 = tick every cycle)
stall_limit  in  STALL_W  max clocks without hall change while speed_set!=0 (0 = stall check off)
hall_signal  in  3  raw hall sensor code
speed_set  out  8  slewed speed to commutation FSM
run_req  out  1  high in RUN/STOPPING
at_speed  out  1  high in RUN when speed_set==target_speed
fault_out  out  1  high in FAULT; drives commutation FSM fault
fault_code  out  2  00 none, 01 external, 10 stall, 11 illegal hall; holds until cleared

Behaviour:
- Reset (reset=0, async): state IDLE, speed_set=0, run_req=0, at_speed=0, fault_out=0, fault_code=00, all counters=0.
- States: IDLE, RUN, STOPPING, FAULT. All outputs are registered; a state change is visible one cycle after the causing input.
- IDLE: start=1 and no fault condition -> RUN. speed_set stays 0.
- RUN: slew toward target_speed on each ramp tick. stop=1 -> STOPPING; if start and stop are both 1, stop wins.
- STOPPING: slew toward 0 on each ramp tick. start=1 (without stop) -> RUN, resuming from the current speed_set. When speed_set reaches 0 -> IDLE.
- Ramp tick: counter runs 0..ramp_div, resets on wrap and on any state change; a tick occurs on the wrap cycle.
- Slew arithmetic: use a 9-bit difference. If |goal - speed_set| <= STEP, load goal; otherwise step by STEP. No overshoot and no wrap. Changing target_speed mid-ramp redirects the slew on the next tick.
- at_speed is registered and is 0 outside RUN.
- Fault detection is active in RUN and STOPPING, and fault_in is also checked in IDLE. Priority: fault_in (01) > illegal hall 000/111 while speed_set!=0 (11) > stall (10).
- Stall counter: increments each cycle while speed_set!=0. It clears on any hall code change, on entry to RUN, and while speed_set==0. It saturates at its maximum. Stall fault when count==stall_limit and stall_limit!=0.
- Any fault -> FAULT. The next cycle has speed_set=0, run_req=0, fault_out=1, fault_code latched. Later faults do not overwrite the latched code.
- FAULT: clear_fault=1 and fault_in=0 -> IDLE, fault_code=00. If fault_in is still 1, clear_fault is ignored.
- Reset asserted mid-ramp or in FAULT returns to the reset values immediately.

Optional Feature:
- Macro BLDC_HALL_SYNC_EN.
- Defined: hall_signal passes through a 2-flop synchronizer before the change and illegal-code checks (+2 cycles of detection latency).
- Undefined: hall_signal is used directly; detection occurs one cycle after the input changes.

Test Plan:
- Ramp up: STEP=1, ramp_div=3, target=10, pulse start -> speed_set +1 every 4 clocks, reaches 10 about 40 clocks later; at_speed=1 thereafter.
- Clamp and redirect: STEP=4, target=10 -> speed_set 4, 8, 10. Then target=2 -> 6, 2; no overshoot.
- Stop and resume: from speed 20, stop=1 -> slews down. start at speed 12 -> RUN, ramps back up. start and stop both 1 -> STOPPING, reaches 0 -> IDLE, run_req=0.
- Stall: stall_limit=100, hall held at 001 with speed_set=5 -> fault_code=10, speed_set=0 by clock about 101. A hall toggle every 50 clocks -> no fault.
- Illegal hall and priority: hall=111 together with fault_in=1 -> fault_code=01. clear_fault while fault_in=1 is ignored; after fault_in drops, clear_fault -> IDLE with fault_code=00.
- Async reset during ramp at speed 30 -> all outputs 0 without waiting for a clk edge; with BLDC_HALL_SYNC_EN defined, stall/illegal detection is confirmed 2 cycles later than without it.

Source files
------------

// File: rtl/bldc_speed_ramp_sequencer_if.sv
// Host/commutation-side signal bundle for bldc_speed_ramp_sequencer.
// master drives commands and hall input; slave is the sequencer itself.
interface bldc_speed_ramp_sequencer_if #(
  parameter int DIV_W   = 16,
  parameter int STALL_W = 20
);
  logic               start;
  logic               stop;
  logic               fault_in;
  logic               clear_fault;
  logic [7:0]         target_speed;
  logic [DIV_W-1:0]   ramp_div;
  logic [STALL_W-1:0] stall_limit;
  logic [2:0]         hall_signal;
  logic [7:0]         speed_set;
  logic               run_req;
  logic               at_speed;
  logic               fault_out;
  logic [1:0]         fault_code;

  modport master (
    output start, stop, fault_in, clear_fault, target_speed, ramp_div,
           stall_limit, hall_signal,
    input  speed_set, run_req, at_speed, fault_out, fault_code
  );

  modport slave (
    input  start, stop, fault_in, clear_fault, target_speed, ramp_div,
           stall_limit, hall_signal,
    output speed_set, run_req, at_speed, fault_out, fault_code
  );
endinterface

// File: rtl/bldc_speed_ramp_sequencer.sv
// Start/stop sequencer that slews speed_set toward a target and latches coded faults.
// Define BLDC_HALL_SYNC_EN to pass hall_signal through a 2-flop synchronizer first.
module bldc_speed_ramp_sequencer #(
  parameter int STEP    = 1,
  parameter int DIV_W   = 16,
  parameter int STALL_W = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  bldc_speed_ramp_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING, FAULT} state_t;

  localparam logic [8:0]         STEP9     = 9'(STEP);
  localparam logic [7:0]         STEP8     = 8'(STEP);
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  state_t             state, state_next;
  logic [7:0]         speed_q, speed_next;
  logic [1:0]         code_q, code_next;
  logic               run_req_q, at_speed_q, fault_out_q;
  logic [DIV_W-1:0]   tick_cnt, tick_cnt_next;
  logic [STALL_W-1:0] stall_cnt, stall_cnt_next;
  logic [2:0]         hall_now, hall_prev;
  logic               moving, tick, hall_illegal, hall_changed, stall_hit;

  // Difference is taken in 9 bits so the clamp-to-goal test never wraps.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] goal);
    logic [8:0] diff;
    if (goal >= cur) begin
      diff = {1'b0, goal} - {1'b0, cur};
      return (diff <= STEP9) ? goal : cur + STEP8;
    end else begin
      diff = {1'b0, cur} - {1'b0, goal};
      return (diff <= STEP9) ? goal : cur - STEP8;
    end
  endfunction

`ifdef BLDC_HALL_SYNC_EN
  logic [2:0] hall_meta, hall_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hall_meta <= '0;
      hall_sync <= '0;
    end else begin
      hall_meta <= bus.hall_signal;
      hall_sync <= hall_meta;
    end
  end

  assign hall_now = hall_sync;
`else
  assign hall_now = bus.hall_signal;
`endif

  assign moving       = (state == RUN) || (state == STOPPING);
  assign tick         = moving && (tick_cnt >= bus.ramp_div);
  assign hall_changed = (hall_now != hall_prev);
  assign hall_illegal = ((hall_now == 3'b000) || (hall_now == 3'b111)) && (speed_q != 8'd0);
  assign stall_hit    = (bus.stall_limit != '0) && (stall_cnt == bus.stall_limit);

  always_comb begin
    state_next     = state;
    code_next      = code_q;
    speed_next     = speed_q;
    tick_cnt_next  = '0;
    stall_cnt_next = stall_cnt;

    case (state)
      IDLE: begin
        if (bus.fault_in) begin
          state_next = FAULT;
          code_next  = 2'b01;
        end else if (bus.start) begin
          state_next = RUN;
        end
      end
      RUN, STOPPING: begin
        if (bus.fault_in) begin
          state_next = FAULT;
          code_next  = 2'b01;
        end else if (hall_illegal) begin
          state_next = FAULT;
          code_next  = 2'b11;
        end else if (stall_hit) begin
          state_next = FAULT;
          code_next  = 2'b10;
        end else if (state == RUN) begin
          if (bus.stop) state_next = STOPPING;
        end else if (bus.start && !bus.stop) begin
          state_next = RUN;
        end else if (speed_q == 8'd0) begin
          state_next = IDLE;
        end
      end
      FAULT: begin
        if (bus.clear_fault && !bus.fault_in) begin
          state_next = IDLE;
          code_next  = 2'b00;
        end
      end
      default: state_next = IDLE;
    endcase

    // Speed only moves on a tick inside a stable RUN/STOPPING interval.
    if ((state_next == IDLE) || (state_next == FAULT)) begin
      speed_next = 8'd0;
    end else if ((state_next == state) && tick) begin
      speed_next = slew(speed_q, (state == RUN) ? bus.target_speed : 8'd0);
    end

    if (moving && (state_next == state) && !tick) begin
      tick_cnt_next = tick_cnt + DIV_W'(1);
    end

    if ((speed_q == 8'd0) || hall_changed || ((state_next == RUN) && (state != RUN))) begin
      stall_cnt_next = '0;
    end else if (stall_cnt != STALL_MAX) begin
      stall_cnt_next = stall_cnt + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      speed_q     <= '0;
      code_q      <= '0;
      run_req_q   <= 1'b0;
      at_speed_q  <= 1'b0;
      fault_out_q <= 1'b0;
      tick_cnt    <= '0;
      stall_cnt   <= '0;
      hall_prev   <= '0;
    end else begin
      state       <= state_next;
      speed_q     <= speed_next;
      code_q      <= code_next;
      run_req_q   <= (state_next == RUN) || (state_next == STOPPING);
      at_speed_q  <= (state_next == RUN) && (speed_next == bus.target_speed);
      fault_out_q <= (state_next == FAULT);
      tick_cnt    <= tick_cnt_next;
      stall_cnt   <= stall_cnt_next;
      hall_prev   <= hall_now;
    end
  end

  assign bus.speed_set  = speed_q;
  assign bus.run_req    = run_req_q;
  assign bus.at_speed   = at_speed_q;
  assign bus.fault_out  = fault_out_q;
  assign bus.fault_code = code_q;

endmodule
